rect_cmd_ctrl: RTL and testbench

- Upstream command stage for the rectangle pixel generator in the paint path.
- Turns a cursor position and a single click button into a two-corner rectangle command: first click latches corner 1, second click latches corner 2 and the colour.
- Then runs the start/done handshake with the rectangle generator, holding corners and colour stable until the rectangle is finished.

---
 rtl/paint_pkg.sv | 19 +
 rtl/btn_edge.sv | 26 ++
 rtl/rect_cmd_ctrl.sv | 140 ++++++++++++++
 tb/tb_rect_cmd_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/paint_pkg.sv
// Shared constants and FSM state encoding for the paint-path command stages.
package paint_pkg;

    localparam int COORD_W  = 8;
    localparam int X_MAX    = 159;
    localparam int Y_MAX    = 119;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] CLEAR_COLOUR = 3'b000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HAVE1 = 3'd1,
        ARM   = 3'd2,
        DRAW  = 3'd3,
        REL   = 3'd4
    } state_e;

endpackage

// File: rtl/btn_edge.sv
// Registers a synchronised button level and emits a one-cycle pulse on its rising edge.
module btn_edge (
    input  logic clk,
    input  logic resetn,
    input  logic btn_in,
    output logic pulse
);

    logic btn_q;
    logic btn_d;

    assign btn_d = btn_in;

    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would chain flops into wires.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            // Reset as "already pressed" so a button held through reset release is not a click.
            btn_q <= 1'b1;
        end else begin
            btn_q <= btn_d;
        end
    end

    assign pulse = btn_in & ~btn_q;

endmodule

// File: rtl/rect_cmd_ctrl.sv
// Two-click rectangle command capture plus start/done handshake with the rectangle generator.
// Optional full-screen clear command is built when RECT_CLEAR_EN is defined.
module rect_cmd_ctrl #(
    parameter int COORD_W = paint_pkg::COORD_W,
    parameter int X_MAX   = paint_pkg::X_MAX,
    parameter int Y_MAX   = paint_pkg::Y_MAX
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [COORD_W-1:0]            cur_x,
    input  logic [COORD_W-1:0]            cur_y,
    input  logic                          btn,
    input  logic                          cancel,
    input  logic [paint_pkg::COLOUR_W-1:0] colour_in,
    input  logic                          draw_done,
`ifdef RECT_CLEAR_EN
    input  logic                          clear_req,
`endif
    output logic [COORD_W-1:0]            x1,
    output logic [COORD_W-1:0]            y1,
    output logic [COORD_W-1:0]            x2,
    output logic [COORD_W-1:0]            y2,
    output logic                          start_draw,
    output logic [paint_pkg::COLOUR_W-1:0] colour_out,
    output logic                          pending,
    output logic                          busy
);

    import paint_pkg::*;

    localparam logic [COORD_W-1:0] X_LIM = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(Y_MAX);

    state_e                state_q, state_d;
    logic [COORD_W-1:0]    x1_q, x1_d, y1_q, y1_d;
    logic [COORD_W-1:0]    x2_q, x2_d, y2_q, y2_d;
    logic [COLOUR_W-1:0]   colour_q, colour_d;
    logic                  start_q, start_d;
    logic                  pending_q, pending_d;
    logic                  busy_q, busy_d;

    logic                  click;
    logic [COORD_W-1:0]    cap_x, cap_y;

    btn_edge u_btn_edge (
        .clk    (clk),
        .resetn (resetn),
        .btn_in (btn),
        .pulse  (click)
    );

    assign cap_x = (cur_x > X_LIM) ? X_LIM : cur_x;
    assign cap_y = (cur_y > Y_LIM) ? Y_LIM : cur_y;

    always_comb begin
        // NOTE: every *_d gets a default first so no path through the case leaves one unassigned (no latches).
        state_d  = state_q;
        x1_d     = x1_q;
        y1_d     = y1_q;
        x2_d     = x2_q;
        y2_d     = y2_q;
        colour_d = colour_q;

`ifdef RECT_CLEAR_EN
        if (clear_req && (state_q == IDLE || state_q == HAVE1)) begin
            x1_d     = '0;
            y1_d     = '0;
            x2_d     = X_LIM;
            y2_d     = Y_LIM;
            colour_d = CLEAR_COLOUR;
            state_d  = ARM;
        end else
`endif
        begin
            unique case (state_q)
                IDLE: begin
                    if (click) begin
                        x1_d    = cap_x;
                        y1_d    = cap_y;
                        state_d = HAVE1;
                    end
                end
                HAVE1: begin
                    if (cancel) begin
                        state_d = IDLE;
                    end else if (click) begin
                        x2_d     = cap_x;
                        y2_d     = cap_y;
                        colour_d = colour_in;
                        state_d  = ARM;
                    end
                end
                // A repeat command can still see the previous Done here, so ARM never looks at it.
                ARM:     state_d = DRAW;
                DRAW:    if (draw_done) state_d = REL;
                REL:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Status outputs are decoded from the next state so they register alongside it.
        pending_d = (state_d == HAVE1);
        start_d   = (state_d == ARM) || (state_d == DRAW);
        busy_d    = (state_d == ARM) || (state_d == DRAW) || (state_d == REL);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= IDLE;
            x1_q      <= '0;
            y1_q      <= '0;
            x2_q      <= '0;
            y2_q      <= '0;
            colour_q  <= '0;
            start_q   <= 1'b0;
            pending_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            x2_q      <= x2_d;
            y2_q      <= y2_d;
            colour_q  <= colour_d;
            start_q   <= start_d;
            pending_q <= pending_d;
            busy_q    <= busy_d;
        end
    end

    assign x1         = x1_q;
    assign y1         = y1_q;
    assign x2         = x2_q;
    assign y2         = y2_q;
    assign colour_out = colour_q;
    assign start_draw = start_q;
    assign pending    = pending_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_rect_cmd_ctrl.sv
// Self-checking bench for rect_cmd_ctrl: scenario tasks against a clamp-and-handshake reference model.
module tb_rect_cmd_ctrl;

    localparam int XM = 159;
    localparam int YM = 119;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] cur_x = '0, cur_y = '0;
    logic       btn = 1'b0, cancel = 1'b0;
    logic [2:0] colour_in = '0;
    logic       draw_done = 1'b0;
`ifdef RECT_CLEAR_EN
    logic       clear_req = 1'b0;
`endif
    logic [7:0] x1, y1, x2, y2;
    logic       start_draw, pending, busy;
    logic [2:0] colour_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rect_cmd_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .cur_x      (cur_x),
        .cur_y      (cur_y),
        .btn        (btn),
        .cancel     (cancel),
        .colour_in  (colour_in),
        .draw_done  (draw_done),
`ifdef RECT_CLEAR_EN
        .clear_req  (clear_req),
`endif
        .x1         (x1),
        .y1         (y1),
        .x2         (x2),
        .y2         (y2),
        .start_draw (start_draw),
        .colour_out (colour_out),
        .pending    (pending),
        .busy       (busy)
    );

    function automatic logic [7:0] clamp(input logic [7:0] v, input int lim);
        return (int'(v) > lim) ? 8'(lim) : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise btn for one edge; the click takes effect at that edge.
    task automatic press(input logic [7:0] x, input logic [7:0] y, input logic [2:0] c);
        cur_x = x;
        cur_y = y;
        colour_in = c;
        btn = 1'b1;
        tick();
        btn = 1'b0;
    endtask

    // One full command: two clicks, hold start for `delay` cycles, then Done.
    task automatic run_cmd(input string tag,
                           input logic [7:0] ax, input logic [7:0] ay,
                           input logic [7:0] bx, input logic [7:0] by,
                           input logic [2:0] col, input int delay,
                           input bit hold_done, input bit poke);
        logic [34:0] exp_cmd;
        exp_cmd = {clamp(ax, XM), clamp(ay, YM), clamp(bx, XM), clamp(by, YM), col};

        press(ax, ay, ~col);
        checks++;
        if ({pending, start_draw, busy} !== 3'b100) begin
            failures++;
            $display("FAIL %s_first: pending/start/busy got=%b exp=100", tag, {pending, start_draw, busy});
        end
        tick();
        press(bx, by, col);
        checks++;
        if ({pending, start_draw, busy} !== 3'b011) begin
            failures++;
            $display("FAIL %s_start: pending/start/busy got=%b exp=011", tag, {pending, start_draw, busy});
        end
        checks++;
        if ({x1, y1, x2, y2, colour_out} !== exp_cmd) begin
            failures++;
            $display("FAIL %s_cmd: got=%h exp=%h", tag, {x1, y1, x2, y2, colour_out}, exp_cmd);
        end

        for (int i = 1; i <= delay; i++) begin
            tick();
            if (i == 1) draw_done = 1'b0;
            if (poke && i == 2) begin
                cur_x = ~bx;
                cur_y = ~by;
                btn = 1'b1;
            end
            if (poke && i == 3) btn = 1'b0;
            checks++;
            if (start_draw !== 1'b1 || busy !== 1'b1 || {x1, y1, x2, y2, colour_out} !== exp_cmd) begin
                failures++;
                $display("FAIL %s_hold cycle %0d: start=%b busy=%b cmd=%h exp start=1 busy=1 cmd=%h",
                         tag, i, start_draw, busy, {x1, y1, x2, y2, colour_out}, exp_cmd);
            end
        end

        draw_done = 1'b1;
        tick();
        checks++;
        if ({start_draw, busy, pending} !== 3'b010) begin
            failures++;
            $display("FAIL %s_release: start/busy/pending got=%b exp=010", tag, {start_draw, busy, pending});
        end
        if (!hold_done) draw_done = 1'b0;
        tick();
        checks++;
        if ({start_draw, busy, pending} !== 3'b000) begin
            failures++;
            $display("FAIL %s_idle: start/busy/pending got=%b exp=000", tag, {start_draw, busy, pending});
        end
        checks++;
        if ({x1, y1, x2, y2, colour_out} !== exp_cmd) begin
            failures++;
            $display("FAIL %s_after: got=%h exp=%h", tag, {x1, y1, x2, y2, colour_out}, exp_cmd);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        tick();
        press(8'd33, 8'd44, 3'd5);
        tick();
        press(8'd55, 8'd66, 3'd6);
        tick();
        checks++;
        if (start_draw !== 1'b1) begin
            failures++;
            $display("FAIL reset_setup: start got=%b exp=1", start_draw);
        end
        btn = 1'b1;
        resetn = 1'b0;
        tick();
        checks++;
        if ({x1, y1, x2, y2, colour_out, start_draw, pending, busy} !== 41'd0) begin
            failures++;
            $display("FAIL reset_outputs: got=%h exp=0", {x1, y1, x2, y2, colour_out, start_draw, pending, busy});
        end
        resetn = 1'b1;
        repeat (3) tick();
        checks++;
        if ({pending, busy, start_draw} !== 3'b000) begin
            failures++;
            $display("FAIL reset_held_btn: pending/busy/start got=%b exp=000", {pending, busy, start_draw});
        end
        btn = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        run_cmd("basic", 8'd10, 8'd20, 8'd40, 8'd5, 3'b100, 29, 1'b0, 1'b0);
    endtask

    task automatic test_clamp();
        run_cmd("clamp", 8'd200, 8'd250, 8'd200, 8'd250, 3'b011, 5, 1'b0, 1'b0);
    endtask

    task automatic test_cancel();
        press(8'd12, 8'd34, 3'd1);
        tick();
        cur_x = 8'd90;
        cur_y = 8'd91;
        cancel = 1'b1;
        btn = 1'b1;
        tick();
        cancel = 1'b0;
        btn = 1'b0;
        checks++;
        if ({pending, start_draw, busy} !== 3'b000) begin
            failures++;
            $display("FAIL cancel_state: pending/start/busy got=%b exp=000", {pending, start_draw, busy});
        end
        checks++;
        if ({x1, y1} !== {8'd12, 8'd34}) begin
            failures++;
            $display("FAIL cancel_keep: x1/y1 got=%h exp=%h", {x1, y1}, {8'd12, 8'd34});
        end
        repeat (3) tick();
        checks++;
        if ({pending, start_draw} !== 2'b00) begin
            failures++;
            $display("FAIL cancel_quiet: pending/start got=%b exp=00", {pending, start_draw});
        end
    endtask

    task automatic test_back_to_back();
        run_cmd("b2b_a", 8'd1, 8'd2, 8'd3, 8'd4, 3'b010, 6, 1'b1, 1'b0);
        run_cmd("b2b_b", 8'd77, 8'd66, 8'd77, 8'd66, 3'b111, 8, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            run_cmd("rand", 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                    3'($urandom), int'($urandom_range(4, 12)), n[0], 1'b1);
        end
        draw_done = 1'b0;
        tick();
    endtask

`ifdef RECT_CLEAR_EN
    task automatic test_clear();
        press(8'd70, 8'd80, 3'd5);
        tick();
        clear_req = 1'b1;
        cancel = 1'b1;
        btn = 1'b1;
        tick();
        clear_req = 1'b0;
        cancel = 1'b0;
        btn = 1'b0;
        checks++;
        if ({start_draw, busy, pending} !== 3'b110) begin
            failures++;
            $display("FAIL clear_start: start/busy/pending got=%b exp=110", {start_draw, busy, pending});
        end
        checks++;
        if ({x1, y1, x2, y2, colour_out} !== {8'd0, 8'd0, 8'd159, 8'd119, 3'b000}) begin
            failures++;
            $display("FAIL clear_cmd: got=%h exp=%h", {x1, y1, x2, y2, colour_out},
                     {8'd0, 8'd0, 8'd159, 8'd119, 3'b000});
        end
        repeat (4) tick();
        draw_done = 1'b1;
        tick();
        draw_done = 1'b0;
        checks++;
        if (start_draw !== 1'b0) begin
            failures++;
            $display("FAIL clear_release: start got=%b exp=0", start_draw);
        end
        tick();
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) tick();
        test_reset();
        test_basic();
        test_clamp();
        test_cancel();
        test_back_to_back();
        test_random();
`ifdef RECT_CLEAR_EN
        test_clear();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
